uart_tx_arbiter: RTL and testbench

Shares one `tx_uart` serializer among NREQ byte-stream requesters. It arbitrates round-robin, locks the grant for a whole packet (until a byte flagged `last`), and sequences each byte into the serializer. Completion is detected by monitoring the serializer's bit counter. It sits between the firmware/debug byte sources and `tx_uart`; `o_start_tx`/`o_tx_data` connect to `i_start_tx`/`i_data`, and `out_bit_tx` feeds `i_bit_tx`.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: idle bit index, default
// byte width and the arbiter FSM state encoding.
package uart_pkg;

    // Bit index reported by tx_uart when no frame is in flight.
    localparam logic [3:0] UART_BIT_IDLE = 4'd15;

    // Default payload width of one serialized byte.
    localparam int UART_DW = 8;

    typedef enum logic [2:0] {
        ST_ARB       = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after
// i_ptr, wrapping modulo NREQ. i_ptr must be below NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic            o_found,
    output logic [PW-1:0]   o_idx
);

    logic [NREQ-1:0] w_hit;
    logic [PW-1:0]   w_cand [NREQ];

    // Candidate index for each scan offset, wrapped explicitly so that
    // non-power-of-2 NREQ never produces an out-of-range index.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [PW:0] w_sum;
            assign w_sum       = {1'b0, i_ptr} + (PW+1)'(gi);
            assign w_cand[gi]  = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ))
                                                          : w_sum[PW-1:0];
            assign w_hit[gi]   = i_req[w_cand[gi]];
        end
    endgenerate

    // Lowest scan offset wins: iterate downwards so earlier offsets overwrite.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_found = 1'b1;
                o_idx   = w_cand[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one tx_uart serializer among
// NREQ byte-stream requesters. Byte completion is tracked through the
// serializer's bit index (15 = idle).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DW           = UART_DW,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [NREQ*DW-1:0]   i_req_data,
    input  logic [NREQ-1:0]      i_req_last,
    output logic [NREQ-1:0]      o_req_ready,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_start_tx,
    output logic [DW-1:0]        o_tx_data,
    input  logic [3:0]           i_bit_tx,
    output logic                 o_busy
);

    localparam int PW = $clog2(NREQ);
    // Keep the timer at least one bit wide even when the timeout is disabled.
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    arb_state_t      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_gidx;
    logic [NREQ-1:0] r_grant;
    logic            r_start;
    logic [DW-1:0]   r_tx_data;
    logic            r_last;
    logic [TW-1:0]   r_timer;

    logic            w_found;
    logic [PW-1:0]   w_pick;
    logic            w_accept;
    logic [DW-1:0]   w_sel_data;
    logic            w_sel_last;
    logic [PW-1:0]   w_ptr_next;
    logic            w_timeout;
    logic            w_timer_inc;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_accept   = |(i_req_valid & o_req_ready);
    assign w_sel_data = i_req_data[r_gidx*DW +: DW];
    assign w_sel_last = i_req_last[r_gidx];
    // The owner after the current one gets first look at the next arbitration.
    assign w_ptr_next = (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
    // The lock drops on the idle cycle that would bring the timer to LOCK_TIMEOUT.
    assign w_timeout   = (LOCK_TIMEOUT != 0) && (r_timer == TW'(LOCK_TIMEOUT - 1));
    assign w_timer_inc = (LOCK_TIMEOUT != 0) && (r_timer != TW'(LOCK_TIMEOUT));

    // Ready is decoded only from registered state, never from the inputs.
    always_comb begin
        o_req_ready = (r_state == ST_LOAD) ? r_grant : '0;
    end

    assign o_grant    = r_grant;
    assign o_start_tx = r_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = (r_state != ST_ARB);

    // Arbitration / byte sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state   <= ST_ARB;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_start   <= 1'b0;
            r_tx_data <= '0;
            r_last    <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_ARB: begin
                    if (w_found) begin
                        r_grant <= NREQ'(1) << w_pick;
                        r_gidx  <= w_pick;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_tx_data <= w_sel_data;
                        r_last    <= w_sel_last;
                        r_timer   <= '0;
                        r_start   <= 1'b1;
                        r_state   <= ST_START;
                    end else if (w_timeout) begin
                        r_ptr   <= w_ptr_next;
                        r_grant <= '0;
                        r_timer <= '0;
                        r_state <= ST_ARB;
                    end else if (w_timer_inc) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (i_bit_tx != UART_BIT_IDLE) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_bit_tx == UART_BIT_IDLE) begin
                        if (r_last) begin
                            r_ptr   <= w_ptr_next;
                            r_grant <= '0;
                            r_state <= ST_ARB;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester instance with a
// LOCK_TIMEOUT of 5 driving a behavioural serializer plus line receiver, and a
// 3-requester instance for pointer wrap.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: NREQ=4, LOCK_TIMEOUT=5 ----------------
    logic [3:0]  a_valid = '0, a_last = '0;
    logic [31:0] a_data = '0;
    logic [3:0]  a_ready, a_grant;
    logic        a_start, a_busy;
    logic [7:0]  a_tx;
    logic [3:0]  a_bit = 4'd15;

    uart_tx_arbiter #(.NREQ(4), .DW(8), .LOCK_TIMEOUT(5)) u_a (
        .clk(clk), .i_reset(i_reset),
        .i_req_valid(a_valid), .i_req_data(a_data), .i_req_last(a_last),
        .o_req_ready(a_ready), .o_grant(a_grant),
        .o_start_tx(a_start), .o_tx_data(a_tx),
        .i_bit_tx(a_bit), .o_busy(a_busy)
    );

    // ---------------- instance B: NREQ=3, no timeout ----------------
    logic [2:0]  b_valid = '0, b_last = '0;
    logic [23:0] b_data = '0;
    logic [2:0]  b_ready, b_grant;
    logic        b_start, b_busy;
    logic [7:0]  b_tx;
    logic [3:0]  b_bit = 4'd15;

    uart_tx_arbiter #(.NREQ(3), .DW(8), .LOCK_TIMEOUT(0)) u_b (
        .clk(clk), .i_reset(i_reset),
        .i_req_valid(b_valid), .i_req_data(b_data), .i_req_last(b_last),
        .o_req_ready(b_ready), .o_grant(b_grant),
        .o_start_tx(b_start), .o_tx_data(b_tx),
        .i_bit_tx(b_bit), .o_busy(b_busy)
    );

    // Serializer model A: 4 clocks per bit, frame = start, 8 data LSB first, stop.
    logic [9:0] a_frame = '1;
    int         a_cnt = 0;
    logic       a_line;
    assign a_line = (a_bit == 4'd15) ? 1'b1 : a_frame[a_bit];

    always @(posedge clk) begin
        if (i_reset) begin
            a_bit <= 4'd15;
            a_cnt <= 0;
        end else if (a_bit == 4'd15) begin
            if (a_start) begin
                a_bit   <= 4'd0;
                a_cnt   <= 0;
                a_frame <= {1'b1, a_tx, 1'b0};
            end
        end else if (a_cnt == 3) begin
            a_cnt <= 0;
            a_bit <= (a_bit == 4'd9) ? 4'd15 : a_bit + 4'd1;
        end else begin
            a_cnt <= a_cnt + 1;
        end
    end

    // Serializer model B: bit index only.
    int b_cnt = 0;
    always @(posedge clk) begin
        if (i_reset) begin
            b_bit <= 4'd15;
            b_cnt <= 0;
        end else if (b_bit == 4'd15) begin
            if (b_start) begin
                b_bit <= 4'd0;
                b_cnt <= 0;
            end
        end else if (b_cnt == 3) begin
            b_cnt <= 0;
            b_bit <= (b_bit == 4'd9) ? 4'd15 : b_bit + 4'd1;
        end else begin
            b_cnt <= b_cnt + 1;
        end
    end

    // Line receiver on A: samples mid-bit, collects bytes, counts framing errors.
    logic       rx_busy = 1'b0;
    int         rx_pos = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;
    always @(negedge clk) begin
        if (i_reset) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (!a_line) begin
                rx_busy <= 1'b1;
                rx_pos  <= 1;
            end
        end else begin
            rx_pos <= rx_pos + 1;
            if (rx_pos == 2 && a_line) rx_ferr <= rx_ferr + 1;
            if (rx_pos >= 6 && rx_pos <= 34 && (rx_pos % 4) == 2) rx_sh <= {a_line, rx_sh[7:1]};
            if (rx_pos == 38) begin
                if (!a_line) rx_ferr <= rx_ferr + 1;
                rx_q.push_back(rx_sh);
                rx_busy <= 1'b0;
            end
        end
    end

    // Activity counters on A.
    int   start_cnt = 0;
    int   start_viol = 0;
    logic watch3 = 1'b0;
    int   leak3 = 0;
    always @(negedge clk) begin
        if (a_start) start_cnt <= start_cnt + 1;
        if (a_start && a_bit != 4'd15) start_viol <= start_viol + 1;
        if (watch3 && a_ready[3]) leak3 <= leak3 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b0;
    endtask

    task automatic a_wait_ready(input logic [3:0] mask, input string tag);
        int n = 0;
        while ((a_ready & mask) == 4'd0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready_in_time"}, 32'(n < 200), 32'd1);
    endtask

    task automatic a_wait_bit(input bit eq_idle, input string tag);
        int n = 0;
        while (((a_bit == 4'd15) != eq_idle) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_bit_in_time"}, 32'(n < 200), 32'd1);
    endtask

    task automatic a_wait_grant0(input string tag);
        int n = 0;
        while (a_grant != 4'd0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_release_in_time"}, 32'(n < 200), 32'd1);
    endtask

    task automatic b_packet(input int k, input logic [7:0] d, input string tag);
        int n = 0;
        b_valid = 3'(1 << k);
        b_last  = 3'b111;
        b_data[k*8 +: 8] = d;
        while ((b_ready & b_valid) == 3'd0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready_in_time"}, 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        b_valid = '0;
        chk({tag, "_start"}, 32'(b_start), 32'd1);
        chk({tag, "_data"}, 32'(b_tx), 32'(d));
        n = 0;
        while (b_grant != 3'd0 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_release_in_time"}, 32'(n < 200), 32'd1);
    endtask

    logic [3:0] exp_g [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

    initial begin
        // ---- 1: single requester, two-byte packet ----
        do_reset();
        chk("rst_grant", 32'(a_grant), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_start", 32'(a_start), 32'd0);
        chk("rst_txdata", 32'(a_tx), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ptr", 32'(u_a.r_ptr), 32'd0);
        start_cnt = 0;
        rx_q.delete();
        a_valid[1] = 1'b1; a_data[15:8] = 8'h41; a_last[1] = 1'b0;
        @(posedge clk); #1;
        chk("t1_ready_lat", 32'(a_ready), 32'b0010);
        chk("t1_grant", 32'(a_grant), 32'b0010);
        chk("t1_busy", 32'(a_busy), 32'd1);
        @(posedge clk); #1;
        chk("t1_start1", 32'(a_start), 32'd1);
        chk("t1_data1", 32'(a_tx), 32'h41);
        chk("t1_ready_off", 32'(a_ready), 32'd0);
        a_data[15:8] = 8'h42; a_last[1] = 1'b1;
        a_wait_bit(1'b0, "t1_ack");
        a_wait_bit(1'b1, "t1_done");
        chk("t1_ready_not_yet", 32'(a_ready), 32'd0);
        @(posedge clk); #1;
        chk("t1_ready2", 32'(a_ready), 32'b0010);
        @(posedge clk); #1;
        a_valid[1] = 1'b0;
        chk("t1_start2", 32'(a_start), 32'd1);
        chk("t1_data2", 32'(a_tx), 32'h42);
        a_wait_grant0("t1");
        chk("t1_ptr", 32'(u_a.r_ptr), 32'd2);
        chk("t1_start_count", 32'(start_cnt), 32'd2);
        chk("t1_rx_count", 32'(rx_q.size()), 32'd2);
        chk("t1_rx_byte0", 32'(rx_q[0]), 32'h41);
        chk("t1_rx_byte1", 32'(rx_q[1]), 32'h42);
        chk("t1_framing", 32'(rx_ferr), 32'd0);

        // ---- 2: requesters 0 and 2 alternate one-byte packets ----
        a_valid = 4'b0101; a_last = 4'b0101;
        a_data = 32'h00A2_00A0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_wait_ready(4'hF, "t2");
            chk("t2_grant", 32'(a_grant), 32'(exp_g[i]));
            @(posedge clk); #1;
            chk("t2_data", 32'(a_tx), (exp_g[i] == 4'b0001) ? 32'hA0 : 32'hA2);
        end
        a_valid = '0;
        a_wait_grant0("t2");

        // ---- 3: 3-byte packet from 0 while 3 waits ----
        do_reset();
        rx_q.delete();
        a_valid = 4'b1001; a_last = 4'b1000;
        a_data = 32'hD300_0010;
        watch3 = 1'b1;
        for (int b = 0; b < 3; b++) begin
            a_data[7:0] = 8'(8'h10 + b);
            a_last[0] = (b == 2);
            a_wait_ready(4'b0001, "t3");
            chk("t3_grant", 32'(a_grant), 32'b0001);
            @(posedge clk); #1;
            chk("t3_data", 32'(a_tx), 32'(8'h10 + b));
        end
        a_valid[0] = 1'b0;
        a_wait_ready(4'b1000, "t3_r3");
        watch3 = 1'b0;
        chk("t3_no_ready3", 32'(leak3), 32'd0);
        chk("t3_grant3", 32'(a_grant), 32'b1000);
        chk("t3_rx_count", 32'(rx_q.size()), 32'd3);
        chk("t3_rx_last", 32'(rx_q[2]), 32'h12);
        @(posedge clk); #1;
        a_valid = '0;
        chk("t3_data3", 32'(a_tx), 32'hD3);
        a_wait_grant0("t3");

        // ---- 4: lock timeout ----
        do_reset();
        a_valid[1] = 1'b1; a_data[15:8] = 8'h55; a_last = '0;
        a_wait_ready(4'b0010, "t4");
        @(posedge clk); #1;
        a_valid[1] = 1'b0;
        a_wait_bit(1'b0, "t4_ack");
        a_wait_bit(1'b1, "t4_done");
        @(posedge clk); #1;
        chk("t4_load_ready", 32'(a_ready), 32'b0010);
        repeat (4) @(posedge clk);
        #1;
        chk("t4_still_locked", 32'(a_grant), 32'b0010);
        @(posedge clk); #1;
        chk("t4_dropped", 32'(a_grant), 32'd0);
        chk("t4_state_arb", 32'(u_a.r_state), 32'(ST_ARB));
        chk("t4_busy", 32'(a_busy), 32'd0);
        a_valid = 4'b0110;
        @(posedge clk); #1;
        chk("t4_next_grant", 32'(a_grant), 32'b0100);

        // ---- 5: reset mid-byte ----
        a_valid = '0;
        do_reset();
        a_valid[0] = 1'b1; a_data[7:0] = 8'h5A; a_last = 4'b0001;
        a_wait_ready(4'b0001, "t5");
        @(posedge clk); #1;
        a_valid = '0;
        begin
            int n = 0;
            while (a_bit != 4'd4 && n < 200) begin
                @(posedge clk); #1; n++;
            end
            chk("t5_bit4_in_time", 32'(n < 200), 32'd1);
        end
        i_reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_grant", 32'(a_grant), 32'd0);
        chk("t5_ready", 32'(a_ready), 32'd0);
        chk("t5_start", 32'(a_start), 32'd0);
        chk("t5_txdata", 32'(a_tx), 32'd0);
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_last", 32'(u_a.r_last), 32'd0);
        chk("t5_ptr", 32'(u_a.r_ptr), 32'd0);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t5_no_start", 32'(a_start), 32'd0);
        end

        // ---- 6: NREQ=3 pointer wrap ----
        b_packet(1, 8'h31, "t6_p1");
        chk("t6_ptr2", 32'(u_b.r_ptr), 32'd2);
        b_packet(2, 8'h32, "t6_p2");
        chk("t6_ptr_wrap", 32'(u_b.r_ptr), 32'd0);
        b_valid = 3'b011;
        @(posedge clk); #1;
        chk("t6_grant0", 32'(b_grant), 32'b001);
        b_valid = '0;

        chk("start_while_busy", 32'(start_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
